// File: rtl/viterbi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : viterbi_ctrl                                                 |
// | Description : Frame sequencer for the 4-state Viterbi decoder. Accepts one |
// |               symbol per handshake, issues the ACS/path-memory step enable,|
// |               requests metric normalization, extracts one decoded bit per  |
// |               step once the path memory is full, and terminates the frame  |
// |               on the tail (state 0).                                       |
// | Ports       : clk_i, rst_ni        clock, async active-low reset           |
// |               start_i              begin a frame (honoured only in IDLE)   |
// |               sym_valid_i/_ready_o symbol handshake from the front end     |
// |               step_en_o            advance ACS metrics and path memory     |
// |               path_clr_o           one-cycle clear of metrics/path memory  |
// |               norm_en_o            subtract normalization constant         |
// |               metric_msb_i         metric MSBs of states 3..0              |
// |               best_state_i         index of the smallest metric            |
// |               path_word_i          register-exchange path memory output    |
// |               out_bit_o/_valid_o   decoded bit towards the sink            |
// |               out_ready_i          sink accepts out_bit_o                  |
// |               busy_o, frame_done_o status                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module viterbi_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 2,
    parameter int DEPTH     = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               sym_valid_i,
    output logic               sym_ready_o,
    output logic               step_en_o,
    output logic               path_clr_o,
    output logic               norm_en_o,
    input  logic [3:0]         metric_msb_i,
    input  logic [1:0]         best_state_i,
    input  logic [4*DEPTH-1:0] path_word_i,
    output logic               out_bit_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               frame_done_o
);

    localparam int c_total = FRAME_LEN + TAIL_LEN;
    localparam int c_nw    = $clog2(c_total + 1);

    // Steps numbered 1..c_total; a bit is emitted for steps DEPTH..FRAME_LEN+DEPTH-1.
    localparam logic [c_nw-1:0] c_n_last  = c_nw'(c_total);
    localparam logic [c_nw-1:0] c_emit_lo = c_nw'(DEPTH);
    localparam logic [c_nw-1:0] c_emit_hi = c_nw'(FRAME_LEN + DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [c_nw-1:0]   n_q, n_d;
    logic              emit_pend_q, emit_pend_d;
    logic              out_bit_q, out_bit_d;
    logic              out_valid_q, out_valid_d;

    logic              w_slot_free;
    logic              w_sym_ready;
    logic              w_step;
    logic              w_capture;
    logic              w_emit;
    logic [c_nw-1:0]   w_n_inc;
    logic [1:0]        w_slice;
    logic [3:0]        w_slice_msb;
    logic              w_sel_bit;

    // MSB (oldest decision) of each state's path slice; state 0 sits on top.
    for (genvar s = 0; s < 4; s++) begin : g_slice
        assign w_slice_msb[s] = path_word_i[(4 - s) * DEPTH - 1];
    end

    assign w_slot_free = !out_valid_q || out_ready_i;
    // A pending bit only blocks new symbols when it has nowhere to go, so a
    // stalled sink throttles the front end without losing decisions.
    assign w_sym_ready = (state_q == S_RUN) && (!emit_pend_q || w_slot_free);
    assign w_step      = sym_valid_i && w_sym_ready;
    assign w_capture   = emit_pend_q && w_slot_free;
    assign w_n_inc     = n_q + 1'b1;
    assign w_emit      = (w_n_inc >= c_emit_lo) && (w_n_inc <= c_emit_hi);
    // After the final tail step the trellis is terminated in state 0.
    assign w_slice     = (n_q == c_n_last) ? 2'd0 : best_state_i;
    assign w_sel_bit   = w_slice_msb[w_slice];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            emit_pend_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            emit_pend_q <= emit_pend_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        emit_pend_d  = emit_pend_q;
        out_bit_d    = out_bit_q;
        out_valid_d  = out_valid_q;
        path_clr_o   = 1'b0;
        frame_done_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    n_d     = '0;
                end
            end
            S_CLEAR: begin
                path_clr_o = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (w_step) begin
                    n_d = w_n_inc;
                    if (w_n_inc == c_n_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Registered flags, so the cycle in which the sink takes the
                // last bit still counts as busy.
                if (!emit_pend_q && !out_valid_q) begin
                    frame_done_o = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture samples the current (pre-step) path word.
        if (w_capture) begin
            out_bit_d   = w_sel_bit;
            out_valid_d = 1'b1;
            emit_pend_d = 1'b0;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // A step on the same edge as a capture re-arms the pending flag.
        if (w_step && w_emit) begin
            emit_pend_d = 1'b1;
        end
    end

    assign sym_ready_o = w_sym_ready;
    assign step_en_o   = w_step;
    assign norm_en_o   = w_step && (&metric_msb_i);
    assign out_bit_o   = out_bit_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_viterbi_ctrl                                              |
// | Description : Self-checking bench for viterbi_ctrl: a per-cycle vector     |
// |               table for start-up, bit extraction, stall and normalization, |
// |               then whole-frame sequences (tail termination, stalled sink,  |
// |               reset in the middle of a frame).                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_viterbi_ctrl;

    localparam int FRAME_LEN = 64;
    localparam int TAIL_LEN  = 2;
    localparam int DEPTH     = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sym_valid, sym_ready, step_en, path_clr, norm_en;
    logic [3:0]  metric_msb;
    logic [1:0]  best_state;
    logic [11:0] path_word;
    logic        out_bit, out_valid, out_ready, busy, frame_done;

    always #5 clk = ~clk;

    viterbi_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .sym_valid_i  (sym_valid),
        .sym_ready_o  (sym_ready),
        .step_en_o    (step_en),
        .path_clr_o   (path_clr),
        .norm_en_o    (norm_en),
        .metric_msb_i (metric_msb),
        .best_state_i (best_state),
        .path_word_i  (path_word),
        .out_bit_o    (out_bit),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    // Output order: sym_ready step_en path_clr norm_en out_bit out_valid busy frame_done
    typedef struct {
        logic        start;
        logic        sv;
        logic        ordy;
        logic [3:0]  msb;
        logic [1:0]  bs;
        logic [11:0] pw;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[15];

    int n_vec = 0;
    int n_err = 0;

    // Per-frame tallies filled by run_to_done.
    int steps, bits, ones, last_bit, last_step, done_cyc, pclr;
    int stall_cyc, stall_rdy, stall_step;

    function automatic logic [7:0] get_out();
        return {sym_ready, step_en, path_clr, norm_en, out_bit, out_valid, busy, frame_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic clear_tallies();
        steps = 0; bits = 0; ones = 0; last_bit = -1; last_step = -1;
        done_cyc = -1; pclr = 0; stall_cyc = 0; stall_rdy = 0; stall_step = 0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        start = 1'b1; sym_valid = 1'b0;
        @(negedge clk);
    endtask

    // Streams symbols until frame_done, optionally holding out_ready low for
    // five cycles starting at stall_at.
    task automatic run_to_done(input int stall_at, input logic [11:0] pw, input logic [1:0] bs);
        bit got_done;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            sym_valid  = 1'b1;
            metric_msb = 4'h0;
            path_word  = pw;
            best_state = bs;
            out_ready  = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            @(negedge clk);
            if (path_clr) pclr++;
            if (step_en) begin
                steps++;
                last_step = cyc;
            end
            if (!out_ready) begin
                stall_cyc++;
                if (sym_ready) stall_rdy++;
                if (step_en) stall_step++;
            end
            if (out_valid && out_ready) begin
                bits++;
                ones += int'(out_bit);
                last_bit = int'(out_bit);
            end
            if (frame_done) begin
                done_cyc = cyc;
                got_done = 1'b1;
            end
        end
        if (!got_done) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: got no frame_done, required one within 400 cycles");
        end
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, frame_done}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd0, 12'h000, 8'b0000_0000}; // IDLE ignores sym_valid
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'h0, 2'd0, 12'h000, 8'b0000_0000}; // start sampled
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd0, 12'h000, 8'b0010_0010}; // CLEAR
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'hF, 2'd0, 12'h000, 8'b1101_0010}; // n=1, norm
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'h7, 2'd0, 12'h000, 8'b1100_0010}; // n=2, no norm
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd0, 12'h000, 8'b1100_0010}; // n=3 emits
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'h0, 2'd0, 12'h800, 8'b1100_0010}; // capture 1, start ignored
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd2, 12'h020, 8'b1100_1110}; // capture 1
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd1, 12'h800, 8'b1000_1110}; // capture 0
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 12'h000, 8'b1100_0110}; // nothing pending: step
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 12'h000, 8'b0000_0110}; // stalled: no ready
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd3, 12'hFFF, 8'b1100_0110}; // capture 1 + step
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 12'h000, 8'b1000_1110}; // capture 0
        vecs[13] = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 12'h000, 8'b1000_0110};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 12'h000, 8'b1000_0010}; // out_valid cleared

        rst_n = 1'b0; start = 1'b0; sym_valid = 1'b0; out_ready = 1'b0;
        metric_msb = 4'h0; best_state = 2'd0; path_word = 12'h000;
        #3;
        check("reset_outputs", {24'd0, get_out()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            start      = vecs[i].start;
            sym_valid  = vecs[i].sv;
            out_ready  = vecs[i].ordy;
            metric_msb = vecs[i].msb;
            best_state = vecs[i].bs;
            path_word  = vecs[i].pw;
            @(negedge clk);
            n_vec++;
            if (get_out() !== vecs[i].exp) begin
                n_err++;
                $display("FAIL vec%0d: outputs %b, required %b", i, get_out(), vecs[i].exp);
            end
        end

        // Finish the frame begun by the table: 7 steps and 5 bits (3 ones) so far.
        clear_tallies();
        steps = 7; bits = 5; ones = 3;
        run_to_done(-1, 12'h800, 2'd3);
        check("f1_steps", steps, 66);
        check("f1_bits", bits, FRAME_LEN);
        check("f1_ones", ones, 4);
        check("f1_last_bit_slice0", last_bit, 1);
        check("f1_full_rate", last_step, 58);
        check("f1_done_latency", done_cyc - last_step, 3);

        // All-zero frame with a five-cycle sink stall in the middle.
        clear_tallies();
        start_frame();
        run_to_done(30, 12'h000, 2'd0);
        check("f2_path_clr", pclr, 1);
        check("f2_steps", steps, 66);
        check("f2_bits", bits, FRAME_LEN);
        check("f2_ones", ones, 0);
        check("f2_stall_cycles", stall_cyc, 5);
        check("f2_stall_ready", stall_rdy, 0);
        check("f2_stall_step", stall_step, 0);
        check("f2_done_latency", done_cyc - last_step, 3);

        // Reset after ten symbols of a frame.
        clear_tallies();
        start_frame();
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; sym_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            if (step_en) steps++;
        end
        check("f3_pre_reset_steps", steps, 10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("f3_async_reset_outputs", {24'd0, get_out()}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sym_valid = 1'b0;

        clear_tallies();
        start_frame();
        run_to_done(-1, 12'h020, 2'd2);
        check("f4_path_clr", pclr, 1);
        check("f4_steps", steps, 66);
        check("f4_bits", bits, FRAME_LEN);
        check("f4_ones", ones, FRAME_LEN - 1);
        check("f4_last_bit_slice0", last_bit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
